hc595_frame_rx: RTL and testbench

Receiver/decoder for the 74HC595 serial display stream that `led_segment` drives. It samples `sclk`/`rclk`/`sdio` and rebuilds each 16-bit latched frame. It then decodes the segment pattern back into the 5-bit display code and keeps an 8-digit shadow of what the panel shows. It serves as the self-check and loopback monitor for the calculator display path, and as a front end for a second mirrored display.

---
 rtl/seg_pkg.sv | 43 ++++
 rtl/hc595_frame_rx_if.sv | 22 ++
 rtl/hc595_frame_rx_decode.sv | 20 ++
 rtl/hc595_frame_rx.sv | 120 ++++++++++++
 tb/tb_hc595_frame_rx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Seven-segment display codes and the code<->pattern table shared by
// led_segment (encoder) and hc595_frame_rx (decoder).
package seg_pkg;

  localparam logic [4:0] SEG_MINUS   = 5'd12;
  localparam logic [4:0] SEG_E       = 5'd15;
  localparam logic [4:0] SEG_BLANK   = 5'd16;
  localparam logic [4:0] SEG_R       = 5'd17;
  localparam logic [4:0] SEG_UNKNOWN = 5'd31;

  localparam int SEG_NUM_CODES = 18;

  // Active-high {g,f,e,d,c,b,a}; codes outside the table show blank.
  function automatic logic [6:0] seg_encode(input logic [4:0] code);
    logic [6:0] p;
    case (code)
      5'd0:    p = 7'h3F;
      5'd1:    p = 7'h06;
      5'd2:    p = 7'h5B;
      5'd3:    p = 7'h4F;
      5'd4:    p = 7'h66;
      5'd5:    p = 7'h6D;
      5'd6:    p = 7'h7D;
      5'd7:    p = 7'h07;
      5'd8:    p = 7'h7F;
      5'd9:    p = 7'h6F;
      5'd10:   p = 7'h77;
      5'd11:   p = 7'h7C;
      5'd12:   p = 7'h40;
      5'd13:   p = 7'h39;
      5'd14:   p = 7'h5E;
      5'd15:   p = 7'h79;
      5'd17:   p = 7'h50;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  function automatic logic sel_onehot_low(input logic [7:0] sel);
    return $onehot(~sel);
  endfunction

endpackage

// File: rtl/hc595_frame_rx_if.sv
// Serial 74HC595 pins plus the decoded display shadow of the receiver.
interface hc595_frame_rx_if;

  logic        sclk_in;
  logic        rclk_in;
  logic        sdio_in;
  logic [39:0] disp_code;
  logic [7:0]  disp_dot;
  logic        frame_valid;
  logic        frame_err;

  modport master (
    output sclk_in, rclk_in, sdio_in,
    input  disp_code, disp_dot, frame_valid, frame_err
  );

  modport slave (
    input  sclk_in, rclk_in, sdio_in,
    output disp_code, disp_dot, frame_valid, frame_err
  );

endinterface

// File: rtl/hc595_frame_rx_decode.sv
// seg_pattern_decode: active-high {dp,g..a} pattern to display code
// by reverse lookup of the shared encoder table.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [4:0] code,
  output logic       dp
);

  always_comb begin
    code = SEG_UNKNOWN;
    for (int i = SEG_NUM_CODES - 1; i >= 0; i--) begin
      if (seg_encode(5'(i)) == pattern[6:0])
        code = 5'(i);
    end
    dp = pattern[7];
  end

endmodule

// File: rtl/hc595_frame_rx.sv
// 74HC595 stream receiver keeping an 8-digit shadow of the panel.
// Define HC595_RX_STRICT_EN to accept only frames of exactly 16 bits.
module hc595_frame_rx
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  hc595_frame_rx_if.slave bus
);

  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] rclk_s;
  logic [SYNC_STAGES-1:0] sdio_s;
  logic sclk_d;
  logic rclk_d;
  logic sclk_rise;
  logic rclk_rise;
  logic sdio_q;

  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic [15:0] sh_nxt;
  logic [4:0]  cnt_nxt;
  logic        cnt_ok;
  logic        accept;

  logic [39:0] code_q;
  logic [7:0]  dot_q;
  logic        valid_q;
  logic        err_q;

  logic [4:0]  dec_code;
  logic        dec_dp;

  // sdio rides an identical pipeline so it lines up with its sclk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s    <= '0;
      rclk_s    <= '0;
      sdio_s    <= '0;
      sclk_d    <= 1'b0;
      rclk_d    <= 1'b0;
      sclk_rise <= 1'b0;
      rclk_rise <= 1'b0;
      sdio_q    <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[SYNC_STAGES-2:0], bus.sclk_in};
      rclk_s    <= {rclk_s[SYNC_STAGES-2:0], bus.rclk_in};
      sdio_s    <= {sdio_s[SYNC_STAGES-2:0], bus.sdio_in};
      sclk_d    <= sclk_s[SYNC_STAGES-1];
      rclk_d    <= rclk_s[SYNC_STAGES-1];
      sclk_rise <= sclk_s[SYNC_STAGES-1] & ~sclk_d;
      rclk_rise <= rclk_s[SYNC_STAGES-1] & ~rclk_d;
      sdio_q    <= sdio_s[SYNC_STAGES-1];
    end
  end

  // Latch looks at the post-shift frame when both edges coincide.
  always_comb begin
    sh_nxt  = shreg;
    cnt_nxt = bit_cnt;
    if (sclk_rise) begin
      sh_nxt  = {shreg[14:0], sdio_q};
      cnt_nxt = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
    end
  end

`ifdef HC595_RX_STRICT_EN
  assign cnt_ok = (cnt_nxt == 5'd16);
`else
  assign cnt_ok = (cnt_nxt >= 5'd16);
`endif

  assign accept = cnt_ok & sel_onehot_low(sh_nxt[7:0]);

  seg_pattern_decode u_dec (
    .pattern (~sh_nxt[15:8]),
    .code    (dec_code),
    .dp      (dec_dp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      code_q  <= {8{SEG_BLANK}};
      dot_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      shreg   <= sh_nxt;
      if (rclk_rise) begin
        bit_cnt <= '0;
        if (accept) begin
          for (int k = 0; k < 8; k++) begin
            if (!sh_nxt[k]) begin
              code_q[5*k +: 5] <= dec_code;
              dot_q[k]         <= dec_dp;
            end
          end
          valid_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        bit_cnt <= cnt_nxt;
      end
    end
  end

  assign bus.disp_code   = code_q;
  assign bus.disp_dot    = dot_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Self-checking bench for hc595_frame_rx: frame table plus
// hand-built corner sequences, checked through a latch scoreboard.
module tb_hc595_frame_rx;

  localparam int SYNC_STAGES = 2;
  localparam int LAT = SYNC_STAGES + 2;

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic        ok;
    int          digit;
    logic [4:0]  code;
    logic        dot;
    string       name;
  } vec_t;

  typedef struct {
    logic        ok;
    logic [39:0] code;
    logic [7:0]  dot;
    int          t0;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sbq[$];
  logic [39:0] mcode;
  logic [7:0]  mdot;

  hc595_frame_rx_if bus ();

  hc595_frame_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.frame_valid || bus.frame_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none",
                 bus.frame_valid, bus.frame_err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_valid"}, 64'(bus.frame_valid), 64'(e.ok));
        chk({e.name, "_err"}, 64'(bus.frame_err), 64'(!e.ok));
        chk({e.name, "_code"}, 64'(bus.disp_code), 64'(e.code));
        chk({e.name, "_dot"}, 64'(bus.disp_dot), 64'(e.dot));
        chk({e.name, "_latency"}, 64'(cyc - e.t0), 64'(LAT));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    @(negedge clk);
    bus.sdio_in = b;
    wait_n(4);
    bus.sclk_in = 1'b1;
    wait_n(4);
    bus.sclk_in = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(f[i]);
  endtask

  task automatic push(input logic ok, input string nm);
    exp_t e;
    e.ok   = ok;
    e.code = mcode;
    e.dot  = mdot;
    e.t0   = cyc;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic latch(input logic ok, input string nm);
    @(negedge clk);
    bus.rclk_in = 1'b1;
    push(ok, nm);
    wait_n(4);
    bus.rclk_in = 1'b0;
    wait_n(4);
  endtask

  task automatic set_digit(input int d, input logic [4:0] c,
                           input logic dp);
    mcode[5*d +: 5] = c;
    mdot[d]         = dp;
  endtask

  vec_t vecs[9];
  logic [15:0] sim_frame;

  initial begin
    vecs[0] = '{32'hB0FB, 16, 1'b1, 2, 5'd3, 1'b0, "seg3_three"};
    vecs[1] = '{32'h79FE, 16, 1'b1, 0, 5'd1, 1'b1, "seg1_one_dp"};
    vecs[2] = '{32'h86BF, 16, 1'b1, 6, 5'd15, 1'b0, "seg7_E"};
    vecs[3] = '{32'hAF7F, 16, 1'b1, 7, 5'd17, 1'b0, "seg8_r"};
    vecs[4] = '{32'hB0F3, 16, 1'b0, 0, 5'd0, 1'b0, "two_sel"};
    vecs[5] = '{32'h7FFF, 15, 1'b0, 0, 5'd0, 1'b0, "short15"};
`ifdef HC595_RX_STRICT_EN
    vecs[6] = '{32'h1F9FE, 17, 1'b0, 0, 5'd0, 1'b0, "long17"};
`else
    vecs[6] = '{32'h1F9FE, 17, 1'b1, 0, 5'd1, 1'b0, "long17"};
`endif
    vecs[7] = '{32'hEEFD, 16, 1'b1, 1, 5'd31, 1'b0, "seg2_unknown"};
    vecs[8] = '{32'h3FEF, 16, 1'b1, 4, 5'd12, 1'b1, "seg5_minus_dp"};

    bus.sclk_in = 1'b0;
    bus.rclk_in = 1'b0;
    bus.sdio_in = 1'b0;
    mcode = {8{5'd16}};
    mdot  = '0;

    wait_n(4);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_code", 64'(bus.disp_code), 64'(mcode));
    chk("reset_dot", 64'(bus.disp_dot), 64'(0));
    chk("reset_valid", 64'(bus.frame_valid), 64'(0));
    chk("reset_err", 64'(bus.frame_err), 64'(0));
    wait_n(100);
    chk("idle_code", 64'(bus.disp_code), 64'(mcode));

    for (int v = 0; v < 9; v++) begin
      shift_bits(vecs[v].frame, vecs[v].nbits);
      if (vecs[v].ok) set_digit(vecs[v].digit, vecs[v].code, vecs[v].dot);
      latch(vecs[v].ok, vecs[v].name);
    end

    // 16th bit and rclk rise land on the same sampling cycle.
    sim_frame = 16'h99FB;
    shift_bits({16'h0, sim_frame} >> 1, 15);
    @(negedge clk);
    bus.sdio_in = sim_frame[0];
    wait_n(4);
    set_digit(2, 5'd4, 1'b0);
    bus.sclk_in = 1'b1;
    bus.rclk_in = 1'b1;
    push(1'b1, "sclk_rclk_same");
    wait_n(4);
    bus.sclk_in = 1'b0;
    bus.rclk_in = 1'b0;
    wait_n(4);

    // Reset in the middle of a frame.
    shift_bits(32'hA5, 8);
    @(negedge clk);
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    @(negedge clk);
    mcode = {8{5'd16}};
    mdot  = '0;
    chk("midrst_code", 64'(bus.disp_code), 64'(mcode));
    chk("midrst_dot", 64'(bus.disp_dot), 64'(0));
    shift_bits(32'hBFFD, 16);
    set_digit(1, 5'd12, 1'b0);
    latch(1'b1, "after_rst_seg2");

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 64'(sbq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
